panda_top_tb_core: RTL and testbench
====================================

// Module: panda_top_tb_core
// PURPOSE
//  Register-mapped core of the PandA top level: one bus slave that decodes
//    byte offsets inside the 0x43C0_0000 register window and drives four
//    PULSE units.
//  Each PULSE unit watches one bit of the system bus, chosen by a register.
//    On a rising edge it waits a programmed delay, then emits a pulse of
//    programmed width.
//  The bus master is the processing-system register BFM; pulse_o feeds the
//    output system bus.
// PARAMETERS
//  SBUS_W    32  width of sysbus_i (INP selects one bit, index 0..SBUS_W-1)
//  NUM_PULSE 4   number of PULSE instances (instance n at offset 0x5000+n*0x100)
// PORTS
//  clk_i       in   1   single system clock (FCLK)
//  reset_i     in   1   asynchronous, active-high reset
//  mem_addr_i  in   16  byte offset in the register window
//  mem_dat_i   in   32  write data
//  mem_wstb_i  in   1   write strobe, one cycle per write
//  mem_rstb_i  in   1   read strobe, one cycle per read
//  mem_dat_o   out  32  read data
//  sysbus_i    in   SBUS_W   system bus bits (trigger sources)
//  pulse_o     out  NUM_PULSE  pulse outputs, one per instance
// BEHAVIOUR
//  Decode
//  - Block select: addr[15:12]==4'h5. Instance select: addr[11:8] < NUM_PULSE.
//  - Register select: addr[7:0].
//  - Writes to any other address are ignored. Reads of any other address return 0.
//  Register map, per instance
//  - 0x00 INP      R/W [4:0]: selects the sysbus_i bit.
//  - 0x08 DELAY_L  R/W [31:0].
//  - 0x0C DELAY_H  R/W [15:0]. DELAY = {H,L}, 48 bit.
//  - 0x10 WIDTH_L  R/W [31:0].
//  - 0x14 WIDTH_H  R/W [15:0]. WIDTH = {H,L}, 48 bit.
//  - 0x18 FORCE_RESET  write strobe, data ignored. Reads return 0.
//  - 0x1C MISSED   RO [31:0]: count of triggers dropped while busy.
//  Bus timing
//  - A write takes effect on the clk_i edge that samples mem_wstb_i.
//  - mem_dat_o is registered and valid 1 cycle after mem_rstb_i.
//  - mem_dat_o holds its value until the next read.
//  Trigger path
//  - The selected bit is registered once to give inp_q; inp_prev is inp_q delayed one cycle.
//  - trig = inp_q & ~inp_prev.
//  PULSE state machine: IDLE, DELAY, HIGH
//  - IDLE: on trig with WIDTH!=0, latch DELAY and WIDTH.
//    - DELAY==0: go to HIGH at the next edge.
//    - Otherwise: go to DELAY and load the counter with DELAY-1.
//    - trig with WIDTH==0 is ignored and not counted as missed.
//  - DELAY: counter decrements each cycle. At 0, go to HIGH and load the counter with WIDTH-1.
//  - HIGH: pulse_o=1. Counter decrements. At 0, go to IDLE.
//  - Net timing: pulse_o rises DELAY+1 edges after the edge where trig=1.
//    It stays high exactly WIDTH cycles.
//  - trig in DELAY or HIGH: ignored, and MISSED increments.
//    MISSED saturates at 0xFFFF_FFFF.
//  - Register writes during DELAY or HIGH apply to the next trigger only.
//  - The 48-bit counters never wrap. Max DELAY/WIDTH = 2^48-1.
//  FORCE_RESET
//  - The next edge forces IDLE, pulse_o=0, MISSED=0.
//  - The edge-detect history is kept.
//  - Simultaneous trig and FORCE_RESET: FORCE_RESET wins and the trigger is dropped.
//  Reset (reset_i=1, asynchronous)
//  - All registers clear to 0. All units go to IDLE.
//  - pulse_o=0, mem_dat_o=0, inp_q=inp_prev=0.
//  - Consequence: a bit that is already high after reset produces one trigger.
//  Instances are fully independent. All share clk_i.
// TESTING
//  1 Program INP=0, DELAY=5, WIDTH=10/20/30/40 on units 0..3; FORCE_RESET each.
//    Raise sysbus_i[0] -> pulse_o[n] rises 6 edges after trig, high for 10/20/30/40 cycles.
//  2 Unit 0: DELAY=0, WIDTH=1; toggle bit 0 high -> pulse_o[0] high for exactly 1 cycle,
//    1 edge after trig.
//  3 Unit 0: DELAY=5, WIDTH=10; second rising edge 3 cycles after the first ->
//    single pulse only, then read 0x501C -> 1.
//  4 Unit 1: WIDTH=0; pulse input -> pulse_o[1] stays 0, read 0x511C -> 0.
//  5 Write 0x5118 mid-pulse on unit 1 -> pulse_o[1] low next cycle; MISSED reads 0.
//  6 Write 0x5008=5, read 0x5008 -> 5 one cycle later; read 0x6000 -> 0;
//    assert reset_i -> all pulse_o=0 immediately.

Source files
------------

// File: rtl/panda_top_tb_core_if.sv
// ----------------------------------------------------------------------------
// panda_top_tb_core_if
//   Register bus between the processing-system register master and the PandA
//   core. A write or read is a one-cycle strobe. Read data is returned one
//   cycle after the read strobe and is held until the next read.
//
//   mem_addr_i  16  byte offset inside the register window
//   mem_dat_i   32  write data
//   mem_wstb_i   1  write strobe, one cycle per write
//   mem_rstb_i   1  read strobe, one cycle per read
//   mem_dat_o   32  registered read data
// ----------------------------------------------------------------------------
interface panda_top_tb_core_if;
    logic [15:0] mem_addr_i;
    logic [31:0] mem_dat_i;
    logic        mem_wstb_i;
    logic        mem_rstb_i;
    logic [31:0] mem_dat_o;

    modport master (
        output mem_addr_i,
        output mem_dat_i,
        output mem_wstb_i,
        output mem_rstb_i,
        input  mem_dat_o
    );

    modport slave (
        input  mem_addr_i,
        input  mem_dat_i,
        input  mem_wstb_i,
        input  mem_rstb_i,
        output mem_dat_o
    );
endinterface

// File: rtl/panda_top_tb_core.sv
// ----------------------------------------------------------------------------
// panda_top_tb_core
//   Register-mapped core of the PandA top level. Decodes the register bus and
//   drives NUM_PULSE independent PULSE units. Each unit watches one system-bus
//   bit; on its rising edge the unit waits DELAY cycles and then drives its
//   output high for WIDTH cycles (both 48-bit).
//
//   Register block at 0x5000, unit n at 0x5000 + n*0x100:
//     0x00 INP [4:0]   0x08/0x0C DELAY L/H   0x10/0x14 WIDTH L/H
//     0x18 FORCE_RESET (write strobe)        0x1C MISSED (read only)
//
//   clk_i      single system clock
//   reset_i    asynchronous, active-high reset
//   bus        register bus (slave side)
//   sysbus_i   system bus bits, trigger sources
//   pulse_o    pulse outputs, one per unit
// ----------------------------------------------------------------------------
module panda_top_tb_core #(
    parameter int SBUS_W    = 32,
    parameter int NUM_PULSE = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    panda_top_tb_core_if.slave   bus,
    input  logic [SBUS_W-1:0]    sysbus_i,
    output logic [NUM_PULSE-1:0] pulse_o
);

    localparam logic [3:0] BLOCK_ID    = 4'h5;
    localparam logic [7:0] REG_INP     = 8'h00;
    localparam logic [7:0] REG_DELAY_L = 8'h08;
    localparam logic [7:0] REG_DELAY_H = 8'h0C;
    localparam logic [7:0] REG_WIDTH_L = 8'h10;
    localparam logic [7:0] REG_WIDTH_H = 8'h14;
    localparam logic [7:0] REG_FORCE   = 8'h18;
    localparam logic [7:0] REG_MISSED  = 8'h1C;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_HIGH
    } state_t;

    logic                       blk_sel;
    logic [3:0]                 inst_sel;
    logic [7:0]                 reg_sel;
    logic [NUM_PULSE-1:0][31:0] rd_word;
    logic [31:0]                rd_mux;

    assign blk_sel  = (bus.mem_addr_i[15:12] == BLOCK_ID);
    assign inst_sel = bus.mem_addr_i[11:8];
    assign reg_sel  = bus.mem_addr_i[7:0];

    for (genvar n = 0; n < NUM_PULSE; n++) begin : g_pulse
        logic [4:0]  inp_r;
        logic [47:0] delay_r;
        logic [47:0] width_r;
        logic [47:0] width_lat;
        logic [47:0] count;
        logic [31:0] missed;
        state_t      state;
        logic        inp_q;
        logic        inp_prev;
        logic        pulse_q;
        logic        trig;
        logic        wr_en;
        logic        force_rst;

        // Out-of-range instance numbers never match any n, so those writes
        // fall on the floor without a separate range check.
        assign wr_en     = bus.mem_wstb_i && blk_sel && (int'(inst_sel) == n);
        assign force_rst = wr_en && (reg_sel == REG_FORCE);
        assign trig      = inp_q && !inp_prev;
        assign pulse_o[n] = pulse_q;

        // Configuration registers. A write lands on the edge that samples
        // the strobe; a unit already running keeps its latched copy.
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                inp_r   <= '0;
                delay_r <= '0;
                width_r <= '0;
            end else if (wr_en) begin
                case (reg_sel)
                    REG_INP:     inp_r          <= bus.mem_dat_i[4:0];
                    REG_DELAY_L: delay_r[31:0]  <= bus.mem_dat_i;
                    REG_DELAY_H: delay_r[47:32] <= bus.mem_dat_i[15:0];
                    REG_WIDTH_L: width_r[31:0]  <= bus.mem_dat_i;
                    REG_WIDTH_H: width_r[47:32] <= bus.mem_dat_i[15:0];
                    default: ;
                endcase
            end
        end

        // Edge-detect history. FORCE_RESET deliberately leaves it alone so a
        // level that is already high does not re-trigger after a force.
        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                inp_q    <= 1'b0;
                inp_prev <= 1'b0;
            end else begin
                inp_q    <= sysbus_i[inp_r];
                inp_prev <= inp_q;
            end
        end

        // Pulse sequencer. The counter is loaded with N-1 so that DELAY
        // cycles are spent waiting and WIDTH cycles are spent high.
        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                state     <= ST_IDLE;
                count     <= '0;
                width_lat <= '0;
                pulse_q   <= 1'b0;
                missed    <= '0;
            end else if (force_rst) begin
                // Force wins over a trigger arriving on the same edge.
                state   <= ST_IDLE;
                pulse_q <= 1'b0;
                missed  <= '0;
            end else begin
                if (trig && (state != ST_IDLE) && (missed != '1)) begin
                    missed <= missed + 32'd1;
                end
                case (state)
                    ST_IDLE: begin
                        if (trig && (width_r != '0)) begin
                            width_lat <= width_r;
                            if (delay_r == '0) begin
                                state   <= ST_HIGH;
                                pulse_q <= 1'b1;
                                count   <= width_r - 48'd1;
                            end else begin
                                state <= ST_DELAY;
                                count <= delay_r - 48'd1;
                            end
                        end
                    end
                    ST_DELAY: begin
                        if (count == '0) begin
                            state   <= ST_HIGH;
                            pulse_q <= 1'b1;
                            count   <= width_lat - 48'd1;
                        end else begin
                            count <= count - 48'd1;
                        end
                    end
                    ST_HIGH: begin
                        if (count == '0) begin
                            state   <= ST_IDLE;
                            pulse_q <= 1'b0;
                        end else begin
                            count <= count - 48'd1;
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        pulse_q <= 1'b0;
                    end
                endcase
            end
        end

        // Per-unit read-back word; FORCE_RESET and unmapped offsets read 0.
        logic [31:0] rd_val;

        // NOTE: rd_val gets a default before the case so no path leaves it
        // unassigned, which would otherwise infer a latch.
        always_comb begin
            rd_val = '0;
            case (reg_sel)
                REG_INP:     rd_val = {27'd0, inp_r};
                REG_DELAY_L: rd_val = delay_r[31:0];
                REG_DELAY_H: rd_val = {16'd0, delay_r[47:32]};
                REG_WIDTH_L: rd_val = width_r[31:0];
                REG_WIDTH_H: rd_val = {16'd0, width_r[47:32]};
                REG_MISSED:  rd_val = missed;
                default:     rd_val = '0;
            endcase
        end

        assign rd_word[n] = rd_val;
    end

    // Unit select for reads; anything outside the block or past the last
    // unit returns 0.
    always_comb begin
        rd_mux = '0;
        if (blk_sel) begin
            for (int i = 0; i < NUM_PULSE; i++) begin
                if (int'(inst_sel) == i) begin
                    rd_mux = rd_word[i];
                end
            end
        end
    end

    // Read data is captured on the read strobe and held until the next read.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            bus.mem_dat_o <= '0;
        end else if (bus.mem_rstb_i) begin
            bus.mem_dat_o <= rd_mux;
        end
    end

endmodule

// File: tb/tb_panda_top_tb_core.sv
// ----------------------------------------------------------------------------
// tb_panda_top_tb_core
//   Scoreboard bench for panda_top_tb_core. A reference model observes the
//   stimulus at every clock edge and predicts, per unit, the edge on which each
//   pulse rises and how many cycles it lasts, plus the value of every read.
//   A monitor on the falling edge compares what the DUT presents against the
//   queued predictions.
// ----------------------------------------------------------------------------
module tb_panda_top_tb_core;
    localparam int SBUS_W    = 32;
    localparam int NUM_PULSE = 4;

    typedef struct packed {
        logic [63:0] rise;
        logic [63:0] width;
    } pulse_t;

    logic                 clk_i   = 1'b0;
    logic                 reset_i = 1'b1;
    logic [SBUS_W-1:0]    sysbus_i = '0;
    logic [NUM_PULSE-1:0] pulse_o;

    panda_top_tb_core_if bus ();

    panda_top_tb_core #(
        .SBUS_W    (SBUS_W),
        .NUM_PULSE (NUM_PULSE)
    ) dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .bus      (bus),
        .sysbus_i (sysbus_i),
        .pulse_o  (pulse_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    longint unsigned cyc = 0;
    pulse_t          exp_pulse [NUM_PULSE][$];
    logic [31:0]     exp_rd [$];

    int unsigned     m_inp    [NUM_PULSE];
    logic [31:0]     m_dl     [NUM_PULSE];
    logic [31:0]     m_dh     [NUM_PULSE];
    logic [31:0]     m_wl     [NUM_PULSE];
    logic [31:0]     m_wh     [NUM_PULSE];
    logic [31:0]     m_missed [NUM_PULSE];
    longint unsigned busy_end [NUM_PULSE];
    longint unsigned act_rise [NUM_PULSE];
    longint unsigned act_fall [NUM_PULSE];
    bit              act      [NUM_PULSE];
    bit              h1       [NUM_PULSE];
    bit              h2       [NUM_PULSE];

    function automatic longint unsigned m_delay(int u);
        return 64'(m_dh[u][15:0]) * 64'h1_0000_0000 + 64'(m_dl[u]);
    endfunction

    function automatic longint unsigned m_width(int u);
        return 64'(m_wh[u][15:0]) * 64'h1_0000_0000 + 64'(m_wl[u]);
    endfunction

    function automatic logic [31:0] model_read(logic [15:0] a);
        int u;
        u = int'(a[11:8]);
        if (a[15:12] != 4'h5 || u >= NUM_PULSE) return 32'd0;
        case (a[7:0])
            8'h00:   return 32'(m_inp[u]);
            8'h08:   return m_dl[u];
            8'h0C:   return {16'd0, m_dh[u][15:0]};
            8'h10:   return m_wl[u];
            8'h14:   return {16'd0, m_wh[u][15:0]};
            8'h1C:   return m_missed[u];
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk_i) begin : model
        logic [15:0] a;
        logic [31:0] d;
        bit          wr;
        bit          trig;
        bit          frc;
        pulse_t      p;
        int          u;
        cyc++;
        if (reset_i) begin
            for (int n = 0; n < NUM_PULSE; n++) begin
                m_inp[n] = 0; m_dl[n] = '0; m_dh[n] = '0; m_wl[n] = '0; m_wh[n] = '0;
                m_missed[n] = '0; busy_end[n] = 0; act[n] = 0; h1[n] = 0; h2[n] = 0;
                exp_pulse[n].delete();
            end
            exp_rd.delete();
        end else begin
            a  = bus.mem_addr_i;
            d  = bus.mem_dat_i;
            wr = bus.mem_wstb_i;
            if (bus.mem_rstb_i) exp_rd.push_back(model_read(a));
            for (int n = 0; n < NUM_PULSE; n++) begin
                trig = h1[n] && !h2[n];
                frc  = wr && a[15:12] == 4'h5 && int'(a[11:8]) == n && a[7:0] == 8'h18;
                if (act[n] && cyc >= act_fall[n]) act[n] = 0;
                if (frc) begin
                    if (act[n]) begin
                        p = exp_pulse[n].pop_back();
                        if (cyc > act_rise[n]) begin
                            p.width = 64'(cyc - act_rise[n]);
                            exp_pulse[n].push_back(p);
                        end
                        act[n] = 0;
                    end
                    busy_end[n] = cyc;
                    m_missed[n] = '0;
                end else if (trig) begin
                    if (cyc <= busy_end[n]) begin
                        if (m_missed[n] != 32'hFFFF_FFFF) m_missed[n] = m_missed[n] + 32'd1;
                    end else if (m_width(n) != 0) begin
                        act_rise[n] = cyc + m_delay(n);
                        act_fall[n] = act_rise[n] + m_width(n);
                        busy_end[n] = act_fall[n];
                        act[n]      = 1;
                        p.rise      = 64'(act_rise[n]);
                        p.width     = 64'(m_width(n));
                        exp_pulse[n].push_back(p);
                    end
                end
                h2[n] = h1[n];
                h1[n] = sysbus_i[m_inp[n]];
            end
            if (wr && a[15:12] == 4'h5 && int'(a[11:8]) < NUM_PULSE) begin
                u = int'(a[11:8]);
                case (a[7:0])
                    8'h00: m_inp[u] = d % 32;
                    8'h08: m_dl[u]  = d;
                    8'h0C: m_dh[u]  = d & 32'h0000_FFFF;
                    8'h10: m_wl[u]  = d;
                    8'h14: m_wh[u]  = d & 32'h0000_FFFF;
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    logic            rd_vld = 1'b0;
    logic [31:0]     last_rd = '0;
    bit              prev_p [NUM_PULSE];
    longint unsigned seen_rise [NUM_PULSE];

    always @(posedge clk_i) rd_vld <= bus.mem_rstb_i && !reset_i;

    always @(negedge clk_i) begin : monitor
        pulse_t      p;
        logic [31:0] e;
        if (reset_i) begin
            last_rd = '0;
            for (int n = 0; n < NUM_PULSE; n++) prev_p[n] = 0;
        end else begin
            if (rd_vld) begin
                if (exp_rd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: got %0h with no read expected", bus.mem_dat_o);
                end else begin
                    e = exp_rd.pop_front();
                    check("rd_data", 64'(bus.mem_dat_o), 64'(e));
                    last_rd = e;
                end
            end else begin
                check("rd_hold", 64'(bus.mem_dat_o), 64'(last_rd));
            end
            for (int n = 0; n < NUM_PULSE; n++) begin
                if (pulse_o[n] && !prev_p[n]) seen_rise[n] = cyc;
                if (!pulse_o[n] && prev_p[n]) begin
                    if (exp_pulse[n].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pulse%0d_unexpected: got pulse at %0d len %0d, none expected",
                                 n, seen_rise[n], cyc - seen_rise[n]);
                    end else begin
                        p = exp_pulse[n].pop_front();
                        check($sformatf("pulse%0d_rise", n), 64'(seen_rise[n]), p.rise);
                        check($sformatf("pulse%0d_width", n), 64'(cyc - seen_rise[n]), p.width);
                    end
                end
                prev_p[n] = pulse_o[n];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    function automatic logic [15:0] reg_addr(int u, logic [7:0] off);
        return 16'h5000 + 16'(u * 256) + {8'h00, off};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk_i);
        bus.mem_addr_i = a;
        bus.mem_dat_i  = d;
        bus.mem_wstb_i = 1'b1;
        @(negedge clk_i);
        bus.mem_wstb_i = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a);
        @(negedge clk_i);
        bus.mem_addr_i = a;
        bus.mem_rstb_i = 1'b1;
        @(negedge clk_i);
        bus.mem_rstb_i = 1'b0;
    endtask

    task automatic set_bit(input int i, input logic v);
        @(negedge clk_i);
        sysbus_i[i] = v;
    endtask

    task automatic program_unit(input int u, input int inp,
                                input longint unsigned dly, input longint unsigned wid);
        bus_write(reg_addr(u, 8'h00), 32'(inp));
        bus_write(reg_addr(u, 8'h08), dly[31:0]);
        bus_write(reg_addr(u, 8'h0C), {16'd0, dly[47:32]});
        bus_write(reg_addr(u, 8'h10), wid[31:0]);
        bus_write(reg_addr(u, 8'h14), {16'd0, wid[47:32]});
    endtask

    logic [7:0] offs [8] = '{8'h00, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h04};

    initial begin
        bus.mem_addr_i = '0;
        bus.mem_dat_i  = '0;
        bus.mem_wstb_i = 1'b0;
        bus.mem_rstb_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("reset_pulse", 64'(pulse_o), 64'd0);
        check("reset_rdata", 64'(bus.mem_dat_o), 64'd0);
        reset_i = 1'b0;
        idle(2);

        // Four units on bit 0, DELAY=5, WIDTH=10/20/30/40.
        for (int n = 0; n < NUM_PULSE; n++) begin
            program_unit(n, 0, 5, 10 * (n + 1));
            bus_write(reg_addr(n, 8'h18), 32'hFFFF_FFFF);
        end
        set_bit(0, 1'b1);
        idle(60);
        set_bit(0, 1'b0);
        for (int n = 1; n < NUM_PULSE; n++) bus_write(reg_addr(n, 8'h00), 32'(n));
        idle(3);

        // DELAY=0, WIDTH=1: single-cycle pulse one edge after the trigger.
        program_unit(0, 0, 0, 1);
        set_bit(0, 1'b1);
        idle(6);
        set_bit(0, 1'b0);
        idle(3);

        // Second rising edge three cycles after the first is missed.
        program_unit(0, 0, 5, 10);
        set_bit(0, 1'b1);
        set_bit(0, 1'b0);
        idle(1);
        set_bit(0, 1'b1);
        idle(20);
        set_bit(0, 1'b0);
        bus_read(16'h501C);

        // WIDTH=0 never fires and is not counted as missed.
        program_unit(1, 1, 2, 0);
        set_bit(1, 1'b1);
        idle(2);
        set_bit(1, 1'b0);
        idle(10);
        bus_read(16'h511C);

        // FORCE_RESET mid-pulse after a missed trigger.
        program_unit(1, 1, 2, 30);
        set_bit(1, 1'b1);
        idle(4);
        set_bit(1, 1'b0);
        set_bit(1, 1'b1);
        idle(5);
        bus_read(16'h511C);
        bus_write(16'h5118, $urandom);
        bus_read(16'h511C);
        set_bit(1, 1'b0);
        idle(5);

        // Register read-back, field widths and unmapped addresses.
        bus_write(16'h5008, 32'd5);
        bus_read(16'h5008);
        bus_read(16'h6000);
        bus_write(16'h5408, 32'h1234_5678);
        bus_read(16'h5408);
        bus_write(16'h5200, 32'hFFFF_FFE3);
        bus_read(16'h5200);
        bus_write(16'h530C, 32'hFFFF_1234);
        bus_read(16'h530C);
        bus_write(16'h530C, 32'd0);
        bus_read(16'h5318);
        idle(2);

        // Asynchronous reset while a pulse is high.
        program_unit(2, 2, 0, 50);
        set_bit(2, 1'b1);
        idle(10);
        check("pre_reset_pulse2", 64'(pulse_o[2]), 64'd1);
        #2;
        reset_i = 1'b1;
        #1;
        check("async_reset_pulse", 64'(pulse_o), 64'd0);
        check("async_reset_rdata", 64'(bus.mem_dat_o), 64'd0);
        idle(3);
        reset_i = 1'b0;
        set_bit(2, 1'b0);
        idle(3);

        // Randomized traffic.
        for (int it = 0; it < 700; it++) begin
            int sel;
            sel = int'($urandom_range(0, 99));
            if (sel < 50) begin
                set_bit(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            end else if (sel < 65) begin
                int          u;
                int          r;
                logic [31:0] d;
                u = int'($urandom_range(0, 4));
                r = int'($urandom_range(0, 5));
                case (r)
                    0:       d = ($urandom & 32'hFFFF_FFE0) | 32'($urandom_range(0, 7));
                    1:       d = 32'($urandom_range(0, 8));
                    3:       d = 32'($urandom_range(0, 12));
                    5:       d = $urandom;
                    default: d = 32'($urandom_range(0, 65535)) << 16;
                endcase
                bus_write(reg_addr(u, offs[r == 0 ? 0 : (r == 1 ? 1 : (r == 2 ? 2 : (r == 3 ? 3 : (r == 4 ? 4 : 5))))]), d);
            end else if (sel < 80) begin
                logic [15:0] a;
                a = reg_addr(int'($urandom_range(0, 4)), offs[$urandom_range(0, 7)]);
                if ($urandom_range(0, 9) == 0) a[15:12] = 4'h6;
                bus_read(a);
            end else begin
                idle(int'($urandom_range(0, 3)));
            end
        end

        // Drain and collect the final MISSED counts.
        @(negedge clk_i);
        sysbus_i = '0;
        idle(80);
        for (int n = 0; n < NUM_PULSE; n++) bus_read(reg_addr(n, 8'h1C));
        idle(3);
        for (int n = 0; n < NUM_PULSE; n++)
            check($sformatf("pulse%0d_pending", n), 64'(exp_pulse[n].size()), 64'd0);
        check("reads_pending", 64'(exp_rd.size()), 64'd0);
        check("final_pulse_low", 64'(pulse_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
